// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the line clock, deframes 11-bit frames.
// Optional macro PS2_RX_PARITY_CHECK_EN drops bytes with bad odd parity and strobes parity_err_o.
module ps2_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       ps2_clk,
  input  logic       rst_n,
  input  logic       ps2_line_clk_i,
  input  logic       ps2_line_data_i,
  output logic [7:0] ps2_key_data_o,
  output logic       ps2_key_data_en_o,
  output logic       frame_err_o,
  output logic       parity_err_o
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic                   line_clk_s, line_data_s;
  logic                   filt_q, filt_d;
  logic [FiltW-1:0]       filt_cnt_q, filt_cnt_d;
  logic                   sample_evt;

  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic [7:0]             key_q, key_d;
  logic                   en_q, en_d;
  logic                   ferr_q, ferr_d;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic                   perr_q, perr_d;
  logic                   parity_ok;
`endif

  always_comb begin
    clk_sync_d     = clk_sync_q << 1;
    clk_sync_d[0]  = ps2_line_clk_i;
    data_sync_d    = data_sync_q << 1;
    data_sync_d[0] = ps2_line_data_i;
  end

  assign line_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign line_data_s = data_sync_q[SYNC_STAGES-1];

  // Filter flips on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (line_clk_s != filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_d = line_clk_s;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign sample_evt = filt_q & ~filt_d;

`ifdef PS2_RX_PARITY_CHECK_EN
  assign parity_ok = ^{shift_q, parity_q};
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = '0;
    key_d     = key_q;
    en_d      = 1'b0;
    ferr_d    = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    perr_d    = 1'b0;
`endif
    if (state_q != StIdle && !sample_evt) begin
      tmo_d = tmo_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (sample_evt && !line_data_s) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (sample_evt) begin
          shift_d   = {line_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (sample_evt) begin
          parity_d = line_data_s;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (sample_evt) begin
          state_d = StIdle;
          if (!line_data_s) begin
            ferr_d = 1'b1;
          end else begin
`ifdef PS2_RX_PARITY_CHECK_EN
            if (!parity_ok) begin
              perr_d = 1'b1;
            end else begin
              key_d = shift_q;
              en_d  = 1'b1;
            end
`else
            key_d = shift_q;
            en_d  = 1'b1;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Line clock stalled mid-frame: abandon the partial byte.
    if (state_q != StIdle && !sample_evt && tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      shift_d   = '0;
      tmo_d     = '0;
      ferr_d    = 1'b1;
    end
  end

  always_ff @(posedge ps2_clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      key_q       <= 8'h00;
      en_q        <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      key_q       <= key_d;
      en_q        <= en_d;
      ferr_q      <= ferr_d;
`ifdef PS2_RX_PARITY_CHECK_EN
      perr_q      <= perr_d;
`endif
    end
  end

  assign ps2_key_data_o    = key_q;
  assign ps2_key_data_en_o = en_q;
  assign frame_err_o       = ferr_q;
`ifdef PS2_RX_PARITY_CHECK_EN
  assign parity_err_o      = perr_q;
`else
  assign parity_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frame-level reference model feeds an expectation queue,
// an independent monitor pops and compares on every output strobe.
module tb_ps2_rx;

  localparam int unsigned Sync = 2;
  localparam int unsigned Filt = 8;
  localparam int unsigned Tmo  = 300;
  localparam int unsigned Half = 20;

  localparam int KEn   = 0;
  localparam int KFrm  = 1;
  localparam int KPar  = 2;

`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit ParChk = 1'b1;
`else
  localparam bit ParChk = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_clk = 1'b1;
  logic       line_data = 1'b1;
  logic [7:0] key_data;
  logic       key_en;
  logic       frame_err;
  logic       parity_err;

  ps2_rx #(
    .SYNC_STAGES   (Sync),
    .FILTER_LEN    (Filt),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .ps2_clk          (clk),
    .rst_n            (rst_n),
    .ps2_line_clk_i   (line_clk),
    .ps2_line_data_i  (line_data),
    .ps2_key_data_o   (key_data),
    .ps2_key_data_en_o(key_en),
    .frame_err_o      (frame_err),
    .parity_err_o     (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         lo;
    int         hi;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] model_last = 8'h00;
  int         last_fall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d, input int lo, input int hi);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.lo   = lo;
    e.hi   = hi;
    sb.push_back(e);
  endtask

  // Reference: odd parity over data+parity; stop=0 is a frame error regardless of parity.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    int lo = Filt;
    int hi = Sync + Filt + 2;
    if (!stop) begin
      expect_ev(KFrm, model_last, lo, hi);
    end else if (ParChk && ((^{d, par}) == 1'b0)) begin
      expect_ev(KPar, model_last, lo, hi);
    end else begin
      model_last = d;
      expect_ev(KEn, d, lo, hi);
    end
  endtask

  task automatic line_bit(input logic b);
    @(negedge clk);
    line_data = b;
    repeat (Half) @(negedge clk);
    line_clk  = 1'b0;
    last_fall = cyc;
    repeat (Half) @(negedge clk);
    line_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) line_bit(bits[i]);
    repeat (3 * Half) @(negedge clk);
    line_data = 1'b1;
  endtask

  task automatic good_frame(input logic [7:0] d);
    model_frame(d, ~(^d), 1'b1);
    send_frame(d, ~(^d), 1'b1, 11);
  endtask

  int   mon_n;
  int   mon_kind;
  int   mon_delta;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      mon_n = int'(key_en) + int'(frame_err) + int'(parity_err);
      if (mon_n != 0) begin
        tests++;
        mon_kind  = key_en ? KEn : (frame_err ? KFrm : KPar);
        mon_delta = cyc - last_fall;
        if (mon_n > 1) begin
          fails++;
          $display("FAIL strobe_onehot: got en=%b ferr=%b perr=%b expected at most one",
                   key_en, frame_err, parity_err);
        end else if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: got kind %0d data %0h expected none",
                   mon_kind, key_data);
        end else begin
          mon_e = sb.pop_front();
          if (mon_kind != mon_e.kind || key_data !== mon_e.data ||
              mon_delta < mon_e.lo || mon_delta > mon_e.hi) begin
            fails++;
            $display("FAIL strobe: got kind %0d data %0h latency %0d expected kind %0d data %0h latency %0d..%0d",
                     mon_kind, key_data, mon_delta, mon_e.kind, mon_e.data, mon_e.lo, mon_e.hi);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       par;
    logic       stop;

    repeat (5) @(negedge clk);
    check("reset_data", 32'(key_data), 32'h00);
    check("reset_en", 32'(key_en), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    check("reset_perr", 32'(parity_err), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    model_frame(8'h75, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1, 11);

    model_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    model_frame(8'h6B, 1'b0, 1'b1);
    send_frame(8'h6B, 1'b0, 1'b1, 11);

    model_frame(8'h72, 1'b0, 1'b1);
    send_frame(8'h72, 1'b0, 1'b1, 11);

    model_frame(8'h74, 1'b1, 1'b0);
    send_frame(8'h74, 1'b1, 1'b0, 11);
    good_frame(8'h74);

    // Stall after start + 4 data bits.
    expect_ev(KFrm, model_last, Tmo, Tmo + Sync + Filt + 4);
    send_frame(8'h6B, 1'b0, 1'b1, 5);
    repeat (Tmo + 50) @(negedge clk);
    good_frame(8'h6B);

    // Sub-threshold low glitch with data low must not start a frame.
    @(negedge clk);
    line_data = 1'b0;
    line_clk  = 1'b0;
    repeat (Filt - 1) @(negedge clk);
    line_clk  = 1'b1;
    line_data = 1'b1;
    repeat (Tmo + 50) @(negedge clk);
    check("glitch_hold", 32'(key_data), 32'(model_last));
    good_frame(8'h1C);

    // Reset in the middle of a frame.
    send_frame(8'h33, 1'b1, 1'b1, 6);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_data", 32'(key_data), 32'h00);
    check("midrst_en", 32'(key_en), 32'h0);
    check("midrst_ferr", 32'(frame_err), 32'h0);
    model_last = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (Tmo + 50) @(negedge clk);
    check("postrst_data", 32'(key_data), 32'h00);
    good_frame(8'h5A);

    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      par  = ~(^d);
      if ($urandom_range(0, 3) == 0) par = ~par;
      stop = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
      model_frame(d, par, stop);
      send_frame(d, par, stop, 11);
    end

    repeat (100) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    check("final_data", 32'(key_data), 32'(model_last));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
